// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the PC, chooses reset vector / hold / +4 / redirect target each cycle.
// Latency: redirect sampled at edge N -> target visible after N, valid fetch after N+1; sequential advance 1/cycle.
// Backpressure: fetch_ready low holds pc with pc_valid asserted; stall parks in HOLD; redirects override both.
module pc_sequencer #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            fetch_ready,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump_valid,
  input  logic [XLEN-1:0] jump_target,
  input  logic            trap_req,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic            flush,
  output logic [XLEN-1:0] epc
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    HOLD  = 2'd2,
    FLUSH = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;

  logic            redirect;
  logic [XLEN-1:0] redirect_raw;
  logic [XLEN-1:0] redirect_tgt;
  logic            fire;

  // Resolve the winning redirect source (trap > jump > branch) and word-align its target.
  always_comb begin
    redirect     = trap_req | jump_valid | branch_taken;
    redirect_raw = branch_target;
    if (trap_req) begin
      redirect_raw = TRAP_VECTOR;
    end else if (jump_valid) begin
      redirect_raw = jump_target;
    end
    redirect_tgt = {redirect_raw[XLEN-1:2], 2'b00};
  end

  // Outputs are the registered PC/EPC and pure decodes of the state.
  assign pc       = pc_q;
  assign epc      = epc_q;
  assign pc_valid = (state_q == RUN);
  assign flush    = (state_q == FLUSH);
  assign fire     = pc_valid & fetch_ready;

  // Next-state and PC selection; a redirect outside BOOT overrides every other choice.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (stall) begin
          state_d = HOLD;
        end else if (fire) begin
          pc_d = pc_q + XLEN'(4);
        end
      end
      HOLD: begin
        if (!stall) begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        if (stall) begin
          state_d = HOLD;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
    if (redirect && (state_q != BOOT)) begin
      state_d = FLUSH;
      pc_d    = redirect_tgt;
      if (trap_req) begin
        epc_d = pc_q;
      end
    end
  end

  // State, PC and EPC registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed scenarios then randomized traffic.
// Every cycle compares pc/pc_valid/flush/epc with a rule-based reference model.
// Inputs driven on the falling edge, outputs sampled on the falling edge after each rising edge.
module tb_pc_sequencer;

  localparam int          XLEN = 32;
  localparam logic [31:0] RV   = 32'h0000_0000;
  localparam logic [31:0] TV   = 32'h0000_0100;

  logic            clk;
  logic            rst_n;
  logic            stall;
  logic            fetch_ready;
  logic            branch_taken;
  logic [XLEN-1:0] branch_target;
  logic            jump_valid;
  logic [XLEN-1:0] jump_target;
  logic            trap_req;
  logic [XLEN-1:0] pc;
  logic            pc_valid;
  logic            flush;
  logic [XLEN-1:0] epc;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: architectural view (pc, epc, whether a fetch is offered,
  // whether a flush is signalled, whether we are in the post-reset boot cycle).
  logic [31:0] m_pc;
  logic [31:0] m_epc;
  logic        m_valid;
  logic        m_flush;
  logic        m_boot;

  pc_sequencer #(
    .XLEN(XLEN),
    .RESET_VECTOR(RV),
    .TRAP_VECTOR(TV)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .stall(stall),
    .fetch_ready(fetch_ready),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .jump_valid(jump_valid),
    .jump_target(jump_target),
    .trap_req(trap_req),
    .pc(pc),
    .pc_valid(pc_valid),
    .flush(flush),
    .epc(epc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply the sequencing rules to the inputs present at a rising edge.
  task automatic model_edge();
    logic [31:0] tgt;
    if (!rst_n) begin
      m_pc = RV; m_epc = '0; m_valid = 1'b0; m_flush = 1'b0; m_boot = 1'b1;
    end else if (m_boot) begin
      m_boot = 1'b0; m_valid = 1'b1; m_flush = 1'b0;
    end else if (trap_req || jump_valid || branch_taken) begin
      tgt = trap_req ? TV : (jump_valid ? jump_target : branch_target);
      if (trap_req) m_epc = m_pc;
      m_pc = tgt & ~32'h3;
      m_valid = 1'b0; m_flush = 1'b1;
    end else if (stall) begin
      m_valid = 1'b0; m_flush = 1'b0;
    end else begin
      if (m_valid && fetch_ready) m_pc = m_pc + 32'd4;
      m_valid = 1'b1; m_flush = 1'b0;
    end
  endtask

  // One clock: model follows the edge, then all outputs are compared.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_eq("pc", pc, m_pc);
    check_eq("pc_valid", {31'd0, pc_valid}, {31'd0, m_valid});
    check_eq("flush", {31'd0, flush}, {31'd0, m_flush});
    check_eq("epc", epc, m_epc);
  endtask

  task automatic idle_inputs();
    stall = 1'b0; fetch_ready = 1'b1;
    branch_taken = 1'b0; jump_valid = 1'b0; trap_req = 1'b0;
    branch_target = '0; jump_target = '0;
  endtask

  initial begin
    m_pc = RV; m_epc = '0; m_valid = 1'b0; m_flush = 1'b0; m_boot = 1'b1;
    rst_n = 1'b0;
    idle_inputs();

    // Reset and run
    step(); step();
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_valid", {31'd0, pc_valid}, 32'd0);
    check_eq("rst_epc", epc, 32'h0);
    rst_n = 1'b1;
    step();
    check_eq("boot_first_pc", pc, 32'h0);
    check_eq("boot_first_valid", {31'd0, pc_valid}, 32'd1);
    step(); check_eq("seq_4", pc, 32'h4);
    step(); check_eq("seq_8", pc, 32'h8);
    step(); check_eq("seq_c", pc, 32'hC);
    step(); check_eq("seq_10", pc, 32'h10);

    // Fetch backpressure
    fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("bp_hold_pc", pc, 32'h10);
      check_eq("bp_hold_valid", {31'd0, pc_valid}, 32'd1);
    end
    fetch_ready = 1'b1;
    step(); check_eq("bp_release", pc, 32'h14);
    step(); step(); step();
    check_eq("at_20", pc, 32'h20);

    // Simultaneous redirects: trap wins
    trap_req = 1'b1; jump_valid = 1'b1; jump_target = 32'h400;
    branch_taken = 1'b1; branch_target = 32'h800;
    step();
    check_eq("trap_pc", pc, 32'h100);
    check_eq("trap_epc", epc, 32'h20);
    check_eq("trap_flush", {31'd0, flush}, 32'd1);
    check_eq("trap_valid", {31'd0, pc_valid}, 32'd0);
    idle_inputs();
    step();
    check_eq("trap_flush_drop", {31'd0, flush}, 32'd0);
    check_eq("trap_run_valid", {31'd0, pc_valid}, 32'd1);
    check_eq("trap_run_pc", pc, 32'h100);

    // Stall vs redirect with unaligned target
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h203;
    step();
    check_eq("stl_br_pc", pc, 32'h200);
    check_eq("stl_br_flush", {31'd0, flush}, 32'd1);
    branch_taken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("stl_hold_valid", {31'd0, pc_valid}, 32'd0);
      check_eq("stl_hold_flush", {31'd0, flush}, 32'd0);
    end
    stall = 1'b0;
    step();
    check_eq("stl_resume_valid", {31'd0, pc_valid}, 32'd1);
    check_eq("stl_resume_pc", pc, 32'h200);
    check_eq("br_keeps_epc", epc, 32'h20);

    // Wrap-around
    jump_valid = 1'b1; jump_target = 32'hFFFF_FFFC;
    step();
    jump_valid = 1'b0;
    step();
    check_eq("wrap_at_top", pc, 32'hFFFF_FFFC);
    step();
    check_eq("wrap_pc", pc, 32'h0);
    check_eq("wrap_valid", {31'd0, pc_valid}, 32'd1);

    // Reset during FLUSH; redirect in BOOT ignored
    jump_valid = 1'b1; jump_target = 32'h300;
    step();
    check_eq("pre_rst_flush", {31'd0, flush}, 32'd1);
    jump_valid = 1'b0; rst_n = 1'b0;
    step();
    check_eq("midrst_pc", pc, RV);
    check_eq("midrst_flush", {31'd0, flush}, 32'd0);
    check_eq("midrst_valid", {31'd0, pc_valid}, 32'd0);
    check_eq("midrst_epc", epc, 32'h0);
    rst_n = 1'b1; branch_taken = 1'b1; branch_target = 32'h500;
    step();
    check_eq("boot_ignore_pc", pc, RV);
    check_eq("boot_ignore_flush", {31'd0, flush}, 32'd0);
    check_eq("boot_ignore_valid", {31'd0, pc_valid}, 32'd1);
    idle_inputs();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst_n         = ($urandom_range(99) >= 2);
      stall         = ($urandom_range(99) < 25);
      fetch_ready   = ($urandom_range(99) < 70);
      trap_req      = ($urandom_range(99) < 5);
      jump_valid    = ($urandom_range(99) < 8);
      branch_taken  = ($urandom_range(99) < 10);
      jump_target   = $urandom;
      branch_target = ($urandom_range(9) == 0) ? 32'hFFFF_FFFF : $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Sequences the CPU program-counter register: owns the PC flip-flops and decides each cycle whether they load the reset vector, hold, or advance by 4. Among redirect sources, the priority order is trap, then jump, then branch. Presents the PC to instruction fetch through a valid/ready handshake. Issues a one-cycle flush pulse after every redirect. Sits between the execute/trap logic (requesters) and the fetch stage (consumer).

## Interface
- XLEN, 32, PC and target width in bits
- RESET_VECTOR, 32'h0000_0000, PC value loaded by reset
- TRAP_VECTOR, 32'h0000_0100, PC value loaded on trap
- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk
- stall  input  1  hazard stall from pipeline; freezes PC
- fetch_ready  input  1  fetch stage accepts pc this cycle
- branch_taken  input  1  branch redirect request
- branch_target  input  XLEN  branch destination
- jump_valid  input  1  jump (jal/jalr) redirect request
- jump_target  input  XLEN  jump destination
- trap_req  input  1  trap/exception redirect request
- pc  output  XLEN  current program counter, registered
- pc_valid  output  1  pc is a valid fetch address this cycle
- flush  output  1  one-cycle pulse: discard younger in-flight instructions
- epc  output  XLEN  pc value captured at the last accepted trap

## Operation
- FSM states: BOOT, RUN, HOLD, FLUSH. All outputs are registered or are pure decodes of the state.
- Reset (rst_n low at an edge): state=BOOT, pc=RESET_VECTOR, pc_valid=0, flush=0, epc=0. Reset wins over every other input. It may be applied mid-operation, including during FLUSH or HOLD.
- BOOT: pc_valid=0. Any redirect request is ignored. Next state is RUN unconditionally.
- RUN: pc_valid=1. A handshake fires when pc_valid & fetch_ready.
  - Redirect pending: load the target (see priority below) and go to FLUSH.
  - Else stall=1: pc holds, go to HOLD.
  - Else fire: pc <= pc + 4, stay in RUN.
  - Else (fetch_ready=0): pc holds, stay in RUN.
- HOLD: pc_valid=0, pc held.
  - Redirect pending: load the target and go to FLUSH.
  - Else stall=0: go to RUN.
  - Else: stay in HOLD.
- FLUSH: flush=1, pc_valid=0, pc held.
  - A new redirect is accepted: load the target and stay in FLUSH, so flush stays high.
  - Else stall=1: go to HOLD.
  - Else: go to RUN.
- Redirect priority: trap_req > jump_valid > branch_taken.
  - Only the winner is applied. Losers are dropped, not queued.
  - trap loads pc=TRAP_VECTOR and epc <= the current pc.
  - jump and branch leave epc unchanged.
- Redirect beats stall and does not depend on fetch_ready.
- Target alignment: bits [1:0] of the loaded target are forced to 0.
- Arithmetic: pc + 4 is computed modulo 2^XLEN. 32'hFFFF_FFFC advances to 32'h0000_0000 with no flag.

## Timing
- Edge numbering: a request sampled at edge N takes effect in the cycle after edge N.
- Redirect sampled at edge N:
  - After N: pc=target, flush=1, pc_valid=0.
  - After N+1: state is RUN with pc_valid=1, if there is no stall and no new redirect.
  - Redirect-to-valid-fetch latency: 2 edges.
- Sequential advance: a fire at edge N makes pc+4 visible after edge N, so back-to-back fetches run at 1 per cycle.
- Reset release: the first edge with rst_n=1 moves BOOT to RUN, so pc_valid=1 after that edge. The first fetch address is RESET_VECTOR.
- stall high at edge N: pc_valid=0 from after N. After stall drops and is sampled low at edge M, pc_valid=1 after M with pc unchanged.
- flush is never high for more than one cycle per accepted redirect. It stays continuously high only while redirects are accepted back-to-back.

## Test plan
- Reset and run: rst_n low for 2 edges, then high, fetch_ready=1 -> after reset pc=0, pc_valid=0; following edges show pc 0x0, 0x4, 0x8, 0xC with pc_valid=1.
- Fetch backpressure: in RUN at pc=0x10, fetch_ready=0 for 3 cycles -> pc stays 0x10, pc_valid=1; when fetch_ready returns to 1 -> 0x14 on the next edge.
- Simultaneous redirects: at pc=0x20, raise trap_req, jump_valid (target 0x400) and branch_taken (target 0x800) together -> pc=0x100, epc=0x20, flush=1 for one cycle, pc_valid=1 at 0x100 one edge later.
- Stall vs redirect: stall=1 held; branch_taken with target 0x203 -> pc=0x200 (aligned), flush pulse, then HOLD with pc_valid=0 until stall=0 -> RUN at 0x200.
- Wrap-around: jump to 0xFFFF_FFFC, fetch_ready=1 -> next pc=0x0000_0000, no error, pc_valid=1.
- Reset mid-FLUSH: assert a redirect, then drive rst_n=0 at the next edge -> pc=RESET_VECTOR, flush=0, pc_valid=0, epc=0, state BOOT; a redirect requested in BOOT is ignored.
